// File: rtl/fdiv_pkg.sv
// Shared constants for the single-precision divide back end: rounding modes,
// flag bit positions, special encodings and the round-increment decision.
package fdiv_pkg;

    localparam int EW       = 10;
    localparam int EXP_BIAS = 127;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

    function automatic logic roundInc(input logic [1:0] rm, input logic sign,
                                      input logic lsb, input logic g, input logic s);
        case (rm)
            RM_RNE:  return g & (s | lsb);
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            default: return ~sign & (g | s);
        endcase
    endfunction

endpackage

// File: rtl/fdiv_rounder.sv
// Combinational round decision for a normalized quotient: increment, carry,
// overflow and underflow. FDIV_SUBNORMAL_EN selects gradual underflow over flush-to-zero.
module fdiv_rounder
    import fdiv_pkg::*;
#(
    parameter int EW = fdiv_pkg::EW
) (
    input  logic                 sign_i,
    input  logic [1:0]           rm_i,
    input  logic signed [EW-1:0] e_i,
    input  logic [23:0]          mant_i,
    input  logic                 g_i,
    input  logic                 s_i,
    output logic [31:0]          result_o,
    output logic [4:0]           flags_o
);
    // Two extra bits of headroom so e+1 and 1-e never wrap
    localparam logic signed [EW+1:0] EZERO = '0;
    localparam logic signed [EW+1:0] EONE  = 1;
    localparam logic signed [EW+1:0] EMAX  = 255;

    logic signed [EW+1:0] eExt, eRnd;
    logic                 tiny, inc, nx, toInf;
    logic [23:0]          mantR;
    logic                 gR, sR;
    logic [24:0]          sum;
    logic [22:0]          fracOut;

`ifdef FDIV_SUBNORMAL_EN
    localparam logic signed [EW+1:0] SHMAX = 26;
    logic signed [EW+1:0] shRaw;
    logic [4:0]           sh;
    logic [49:0]          denorm;

    assign shRaw  = EONE - eExt;
    assign sh     = (shRaw > SHMAX) ? 5'd26 : shRaw[4:0];
    assign denorm = {mant_i, g_i, 25'd0} >> sh;
`endif

    assign eExt = {{2{e_i[EW-1]}}, e_i};
    assign tiny = (eExt <= EZERO);

    always_comb begin
        mantR = mant_i;
        gR    = g_i;
        sR    = s_i;
`ifdef FDIV_SUBNORMAL_EN
        if (tiny) begin
            mantR = denorm[49:26];
            gR    = denorm[25];
            sR    = s_i | (|denorm[24:0]);
        end
`endif
        inc     = roundInc(rm_i, sign_i, mantR[0], gR, sR);
        sum     = {1'b0, mantR} + {24'd0, inc};
        eRnd    = eExt + (sum[24] ? EONE : EZERO);
        fracOut = sum[24] ? sum[23:1] : sum[22:0];
        nx      = gR | sR;
        toInf   = (rm_i == RM_RNE) | ((rm_i == RM_RDN) & sign_i) | ((rm_i == RM_RUP) & ~sign_i);

        result_o          = {sign_i, eRnd[7:0], fracOut};
        flags_o           = '0;
        flags_o[FLAG_NX]  = nx;
        if (tiny) begin
`ifdef FDIV_SUBNORMAL_EN
            // A carry into the hidden bit naturally lands as exponent 1
            result_o         = {sign_i, 7'd0, sum[23], sum[22:0]};
            flags_o[FLAG_UF] = nx;
`else
            result_o         = {sign_i, 31'd0};
            flags_o[FLAG_UF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
`endif
        end else if (eRnd >= EMAX) begin
            result_o         = toInf ? {sign_i, 8'hFF, 23'd0} : {sign_i, MAX_FINITE[30:0]};
            flags_o[FLAG_OF] = 1'b1;
            flags_o[FLAG_NX] = 1'b1;
        end
    end

endmodule

// File: rtl/fdiv_round_pack.sv
// Divide back end: sideband delay line matched to the divider, then normalize (R1)
// and round/pack (R2). Underflow handling is selected by FDIV_SUBNORMAL_EN.
module fdiv_round_pack
    import fdiv_pkg::*;
#(
    parameter int DLY = 3,
    parameter int EW  = fdiv_pkg::EW
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          ena,
    input  logic          start,
    input  logic          sign_in,
    input  logic [EW-1:0] exp_in,
    input  logic          nan_in,
    input  logic          inf_in,
    input  logic          zero_in,
    input  logic          dz_in,
    input  logic          snv_in,
    input  logic [1:0]    rm,
    input  logic [31:0]   q,
    output logic [31:0]   result,
    output logic [4:0]    flags,
    output logic          valid
);
    typedef struct packed {
        logic          start;
        logic          sign;
        logic [EW-1:0] exp;
        logic          nan;
        logic          inf;
        logic          zero;
        logic          dz;
        logic          snv;
        logic [1:0]    rm;
    } side_t;

    typedef struct packed {
        logic          valid;
        logic          sign;
        logic [EW-1:0] e;
        logic [23:0]   mant;
        logic          g;
        logic          s;
        logic          nan;
        logic          inf;
        logic          zero;
        logic          dz;
        logic          snv;
        logic [1:0]    rm;
    } norm_t;

    side_t       sideIn, sideTail;
    side_t       sideDly_q [DLY];
    norm_t       r1_d, r1_q;
    logic [31:0] roundRes, result_d, result_q;
    logic [4:0]  roundFlags, flags_d, flags_q;
    logic        valid_q;

    assign sideIn   = '{start: start, sign: sign_in, exp: exp_in, nan: nan_in, inf: inf_in,
                        zero: zero_in, dz: dz_in, snv: snv_in, rm: rm};
    assign sideTail = sideDly_q[DLY-1];

    // Sideband travels alongside the divider so the tail lines up with q
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DLY; i++) sideDly_q[i] <= '0;
        end else if (ena) begin
            sideDly_q[0] <= sideIn;
            for (int i = 1; i < DLY; i++) sideDly_q[i] <= sideDly_q[i-1];
        end
    end

    always_comb begin
        r1_d       = '0;
        r1_d.valid = sideTail.start;
        r1_d.sign  = sideTail.sign;
        r1_d.nan   = sideTail.nan;
        r1_d.inf   = sideTail.inf;
        r1_d.zero  = sideTail.zero;
        r1_d.dz    = sideTail.dz;
        r1_d.snv   = sideTail.snv;
        r1_d.rm    = sideTail.rm;
        if (q[31]) begin
            r1_d.mant = q[31:8];
            r1_d.g    = q[7];
            r1_d.s    = |q[6:0];
            r1_d.e    = sideTail.exp;
        end else begin
            r1_d.mant = q[30:7];
            r1_d.g    = q[6];
            r1_d.s    = |q[5:0];
            r1_d.e    = sideTail.exp - EW'(1);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)    r1_q <= '0;
        else if (ena) r1_q <= r1_d;
    end

    fdiv_rounder #(.EW(EW)) u_rounder (
        .sign_i  (r1_q.sign),
        .rm_i    (r1_q.rm),
        .e_i     (r1_q.e),
        .mant_i  (r1_q.mant),
        .g_i     (r1_q.g),
        .s_i     (r1_q.s),
        .result_o(roundRes),
        .flags_o (roundFlags)
    );

    // Special operands override the arithmetic path: nan > inf > zero
    always_comb begin
        result_d = roundRes;
        flags_d  = roundFlags;
        if (r1_q.nan) begin
            result_d         = CANON_NAN;
            flags_d          = '0;
            flags_d[FLAG_NV] = r1_q.snv;
        end else if (r1_q.inf) begin
            result_d         = {r1_q.sign, 8'hFF, 23'd0};
            flags_d          = '0;
            flags_d[FLAG_DZ] = r1_q.dz;
        end else if (r1_q.zero) begin
            result_d = {r1_q.sign, 31'd0};
            flags_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
        end else if (ena) begin
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= r1_q.valid;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_fdiv_round_pack.sv
// Scoreboard bench for fdiv_round_pack: directed ops through a modelled divider delay,
// stall and mid-flight reset. Expected underflow results follow FDIV_SUBNORMAL_EN.
module tb_fdiv_round_pack;
    localparam int DLY = 3;

    logic        clk = 1'b0;
    logic        clrn, ena, start, sign_in, nan_in, inf_in, zero_in, dz_in, snv_in;
    logic [9:0]  exp_in;
    logic [1:0]  rm;
    logic [31:0] q, result;
    logic [4:0]  flags;
    logic        valid;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          edgeNo;
    } expT;

    expT         sb [$];
    expT         held;
    logic        haveHeld = 1'b0;
    logic [31:0] qLine [DLY];
    logic        vLine [DLY];
    int          enCount = 0;
    logic        enaAtEdge = 1'b0;
    int          checks = 0;
    int          failures = 0;

    fdiv_round_pack #(.DLY(DLY), .EW(10)) dut (
        .clk(clk), .clrn(clrn), .ena(ena), .start(start), .sign_in(sign_in),
        .exp_in(exp_in), .nan_in(nan_in), .inf_in(inf_in), .zero_in(zero_in),
        .dz_in(dz_in), .snv_in(snv_in), .rm(rm), .q(q),
        .result(result), .flags(flags), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, model the divider's q delay on enabled edges
    task automatic applyStimulus(input logic en, input logic st, input logic sgn,
                                 input logic [9:0] ex, input logic [4:0] spec,
                                 input logic [1:0] rmv, input logic [31:0] qv,
                                 input logic [31:0] er, input logic [4:0] ef);
        ena = en; start = st; sign_in = sgn; exp_in = ex; rm = rmv;
        {nan_in, inf_in, zero_in, dz_in, snv_in} = spec;
        if (st && en) sb.push_back('{er, ef, enCount + DLY + 2});
        @(posedge clk);
        #1;
        if (en && clrn) begin
            for (int i = DLY - 1; i > 0; i--) begin
                qLine[i] = qLine[i-1];
                vLine[i] = vLine[i-1];
            end
            qLine[0] = qv;
            vLine[0] = st;
        end
        q = qLine[DLY-1];
        if (vLine[DLY-1]) checkOutput("q_normalized", {31'd0, q[31] | q[30]}, 32'd1);
        start = 1'b0;
    endtask

    task automatic issue(input logic sgn, input logic [9:0] ex, input logic [4:0] spec,
                         input logic [1:0] rmv, input logic [31:0] qv,
                         input logic [31:0] er, input logic [4:0] ef);
        applyStimulus(1'b1, 1'b1, sgn, ex, spec, rmv, qv, er, ef);
    endtask

    task automatic idle(input logic en);
        applyStimulus(en, 1'b0, 1'b0, 10'd0, 5'd0, 2'b00, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle(1'b1);
        checkOutput("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        enaAtEdge <= ena & clrn;
        if (ena && clrn) enCount <= enCount + 1;
    end

    // Compare on fresh outputs; during stalls the last output must hold
    always @(negedge clk) begin
        if (clrn && valid && enaAtEdge) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", {31'd0, valid}, 32'd0);
            end else begin
                held = sb.pop_front();
                haveHeld = 1'b1;
                checkOutput("result", result, held.res);
                checkOutput("flags", {27'd0, flags}, {27'd0, held.flg});
                checkOutput("latency", 32'(enCount), 32'(held.edgeNo));
            end
        end else if (clrn && valid && haveHeld) begin
            checkOutput("hold_result", result, held.res);
            checkOutput("hold_flags", {27'd0, flags}, {27'd0, held.flg});
        end
    end

    initial begin
        for (int i = 0; i < DLY; i++) begin
            qLine[i] = 32'd0;
            vLine[i] = 1'b0;
        end
        clrn = 1'b0; ena = 1'b0; start = 1'b0; sign_in = 1'b0; exp_in = '0; rm = 2'b00;
        nan_in = 1'b0; inf_in = 1'b0; zero_in = 1'b0; dz_in = 1'b0; snv_in = 1'b0; q = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_flags", {27'd0, flags}, 32'd0);
        checkOutput("reset_valid", {31'd0, valid}, 32'd0);
        clrn = 1'b1;
        idle(1'b1);

        // spec = {nan,inf,zero,dz,snv}; flags = {NV,DZ,OF,UF,NX}
        issue(0, 10'd128, 5'b00000, 2'b00, 32'h8000_0000, 32'h4000_0000, 5'b00000);
        issue(0, 10'd126, 5'b00000, 2'b00, 32'h5555_5555, 32'h3EAA_AAAB, 5'b00001);
        issue(0, 10'd126, 5'b00000, 2'b01, 32'h5555_5555, 32'h3EAA_AAAA, 5'b00001);
        issue(1, 10'd126, 5'b00000, 2'b10, 32'h5555_5555, 32'hBEAA_AAAB, 5'b00001);
        issue(1, 10'd126, 5'b00000, 2'b11, 32'h5555_5555, 32'hBEAA_AAAA, 5'b00001);
        issue(0, 10'd127, 5'b00000, 2'b00, 32'h8000_0180, 32'h3F80_0002, 5'b00001);
        issue(0, 10'd127, 5'b00000, 2'b00, 32'h8000_0080, 32'h3F80_0000, 5'b00001);
        issue(0, 10'd127, 5'b00000, 2'b00, 32'hFFFF_FFFF, 32'h4000_0000, 5'b00001);
        issue(0, 10'd254, 5'b00000, 2'b00, 32'hFFFF_FFFF, 32'h7F80_0000, 5'b00101);
        issue(0, 10'd255, 5'b00000, 2'b00, 32'h8000_0000, 32'h7F80_0000, 5'b00101);
        issue(1, 10'd255, 5'b00000, 2'b01, 32'h8000_0000, 32'hFF7F_FFFF, 5'b00101);
        issue(1, 10'd255, 5'b00000, 2'b10, 32'h8000_0000, 32'hFF80_0000, 5'b00101);
        issue(1, 10'd255, 5'b00000, 2'b11, 32'h8000_0000, 32'hFF7F_FFFF, 5'b00101);
`ifdef FDIV_SUBNORMAL_EN
        issue(0, 10'd0, 5'b00000, 2'b00, 32'h8000_0000, 32'h0040_0000, 5'b00000);
`else
        issue(0, 10'd0, 5'b00000, 2'b00, 32'h8000_0000, 32'h0000_0000, 5'b00011);
`endif
        issue(1, 10'h3E2, 5'b00000, 2'b00, 32'h8000_0000, 32'h8000_0000, 5'b00011);
        issue(0, 10'd128, 5'b10001, 2'b00, 32'h8000_0000, 32'h7FC0_0000, 5'b10000);
        issue(1, 10'd128, 5'b01010, 2'b00, 32'h8000_0000, 32'hFF80_0000, 5'b01000);
        issue(0, 10'd128, 5'b00100, 2'b00, 32'h8000_0000, 32'h0000_0000, 5'b00000);
        issue(1, 10'd128, 5'b00100, 2'b00, 32'h8000_0000, 32'h8000_0000, 5'b00000);
        issue(0, 10'd128, 5'b11000, 2'b00, 32'h8000_0000, 32'h7FC0_0000, 5'b00000);
        drain();

        // Back-to-back pair with a two-cycle stall once the first result is out
        issue(0, 10'd128, 5'b00000, 2'b00, 32'h8000_0000, 32'h4000_0000, 5'b00000);
        issue(0, 10'd126, 5'b00000, 2'b00, 32'h5555_5555, 32'h3EAA_AAAB, 5'b00001);
        repeat (3) idle(1'b1);
        repeat (2) idle(1'b0);
        drain();

        // Third op is discarded by a reset while in flight
        issue(0, 10'd127, 5'b00000, 2'b00, 32'h8000_0000, 32'h3F80_0000, 5'b00000);
        repeat (2) idle(1'b1);
        clrn = 1'b0;
        sb.delete();
        for (int i = 0; i < DLY; i++) begin
            qLine[i] = 32'd0;
            vLine[i] = 1'b0;
        end
        #1;
        checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
        idle(1'b1);
        clrn = 1'b1;
        repeat (8) idle(1'b1);
        checkOutput("post_reset_valid", {31'd0, valid}, 32'd0);
        checkOutput("post_reset_result", result, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
